// File: rtl/divider_pkg.sv
// Shared types and limits for the iterative restoring divider.
package divider_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int WIDTH_MIN = 4;
    localparam int WIDTH_MAX = 32;
    // Wide enough to hold WIDTH_MAX itself.
    localparam int CNT_W     = $clog2(WIDTH_MAX + 1);

endpackage

// File: rtl/divider_iter_if.sv
// Start/operand/result bundle of divider_iter; master drives operands, slave returns results.
interface divider_iter_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/divider_step.sv
// One combinational restoring division step: shift in a dividend bit, trial-subtract the divisor.
module divider_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);
    logic [WIDTH+1:0] shifted;
    logic [WIDTH:0]   trial;

    // The comparison sees the full shifted value, so the wrapped low-bit
    // difference is only ever selected when it is the true result.
    assign shifted = {rem_in, bit_in};
    assign q_bit   = (shifted >= {2'b00, divisor});
    assign trial   = shifted[WIDTH:0] - {1'b0, divisor};
    assign rem_out = q_bit ? trial : shifted[WIDTH:0];
endmodule

// File: rtl/divider_iter.sv
// Iterative restoring divider, one quotient bit per clock, WIDTH+1 edges latency.
// Define DIVIDER_ITER_SIGNED_EN for two's-complement operands and results.
module divider_iter
    import divider_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    divider_iter_if.slave  bus
);
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dsr_q, dsr_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rmd_q, rmd_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     step_rem;
    logic               step_q;

`ifdef DIVIDER_ITER_SIGNED_EN
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;

    assign a_mag = bus.dividend[WIDTH-1] ? (~bus.dividend + 1'b1) : bus.dividend;
    assign b_mag = bus.divisor[WIDTH-1]  ? (~bus.divisor + 1'b1)  : bus.divisor;
`else
    assign a_mag = bus.dividend;
    assign b_mag = bus.divisor;
`endif

    divider_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .bit_in  (dvd_q[WIDTH-1]),
        .divisor (dsr_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
`ifdef DIVIDER_ITER_SIGNED_EN
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    dvd_d = a_mag;
                    dsr_d = b_mag;
                    rem_d = '0;
                    cnt_d = CNT_W'(WIDTH);
`ifdef DIVIDER_ITER_SIGNED_EN
                    neg_quo_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                    neg_rem_d = bus.dividend[WIDTH-1];
`endif
                    // Zero divisor skips iteration and publishes the fixed result now.
                    if (bus.divisor == '0) begin
                        quo_d   = '1;
                        rmd_d   = bus.dividend;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ITER;
                    end
                end
            end
            S_ITER: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[WIDTH-2:0], step_q};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = S_FIX;
            end
            S_FIX: begin
`ifdef DIVIDER_ITER_SIGNED_EN
                quo_d = neg_quo_q ? (~dvd_q + 1'b1) : dvd_q;
                rmd_d = neg_rem_q ? (~rem_q[WIDTH-1:0] + 1'b1) : rem_q[WIDTH-1:0];
`else
                quo_d = dvd_q;
                rmd_d = rem_q[WIDTH-1:0];
`endif
                dbz_d   = 1'b0;
                state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef DIVIDER_ITER_SIGNED_EN
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
`ifdef DIVIDER_ITER_SIGNED_EN
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rmd_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_divider_iter.sv
// Self-checking bench for divider_iter at WIDTH=16 (either build of DIVIDER_ITER_SIGNED_EN).
module tb_divider_iter;
    localparam int W = 16;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   done_cnt;
    exp_t sb[$];
    vec_t vecs[$];

    divider_iter_if #(.WIDTH(W)) bus ();

    divider_iter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.done) done_cnt = done_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Wait (bounded) for done, then pop the scoreboard and compare latency and results.
    task automatic wait_done(input string name);
        exp_t e;
        int   k;
        bit   seen;
        seen = 0;
        k    = 0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            k++;
            if (bus.done) seen = 1;
        end
        if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("[TB] FAIL %s: scoreboard empty, got done=%0b, expected an entry", name, seen);
            return;
        end
        e = sb.pop_front();
        if (!seen) begin
            n_tests++; n_fail++;
            $display("[TB] FAIL %s_timeout: got no done in 64 cycles, expected done after %0d", name, e.lat);
            return;
        end
        check({name, "_lat"}, 32'(k), 32'(e.lat));
        check({name, "_q"},   32'(bus.quotient), 32'(e.q));
        check({name, "_r"},   32'(bus.remainder), 32'(e.r));
        check({name, "_dbz"}, 32'(bus.div_by_zero), 32'(e.dbz));
        $display("[TB] %s: 0x%0h 0x%0h -> q=0x%0h r=0x%0h dbz=%0b lat=%0d",
                 name, 0, 0, bus.quotient, bus.remainder, bus.div_by_zero, k);
    endtask

    // Drive one start pulse with operands, record the expectation, await the result.
    task automatic run_div(input string name, input vec_t v);
        exp_t e;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = v.a;
        bus.divisor  = v.b;
        e.q = v.q; e.r = v.r; e.dbz = v.dbz;
        e.lat = (v.b == '0) ? 1 : W + 2;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = W'($urandom);
        bus.divisor  = W'($urandom);
        wait_done(name);
    endtask

    function automatic vec_t mk(input logic [W-1:0] a, b, q, r, input logic dbz);
        vec_t v;
        v.a = a; v.b = b; v.q = q; v.r = r; v.dbz = dbz;
        return v;
    endfunction

    initial begin
        vec_t v;
        int   dc;
        exp_t e;
        n_tests  = 0;
        n_fail   = 0;
        done_cnt = 0;

        vecs.push_back(mk(16'd100,  16'd7,   16'd14,   16'd2,    1'b0));
        vecs.push_back(mk(16'd1234, 16'd0,   16'hFFFF, 16'd1234, 1'b1));
        vecs.push_back(mk(16'd9,    16'd3,   16'd3,    16'd0,    1'b0));
        vecs.push_back(mk(16'd0,    16'd5,   16'd0,    16'd0,    1'b0));
        vecs.push_back(mk(16'd7,    16'd7,   16'd1,    16'd0,    1'b0));
        vecs.push_back(mk(16'd1000, 16'd1,   16'd1000, 16'd0,    1'b0));
        vecs.push_back(mk(16'h7FFF, 16'h100, 16'h7F,   16'hFF,   1'b0));
        vecs.push_back(mk(16'd5,    16'd9,   16'd0,    16'd5,    1'b0));
`ifdef DIVIDER_ITER_SIGNED_EN
        vecs.push_back(mk(16'hFF9C, 16'd7,   16'hFFF2, 16'hFFFE, 1'b0));
        vecs.push_back(mk(16'h8000, 16'hFFFF,16'h8000, 16'h0000, 1'b0));
        vecs.push_back(mk(16'd100,  16'hFFF9,16'hFFF2, 16'd2,    1'b0));
        vecs.push_back(mk(16'hFF9C, 16'hFFF9,16'd14,   16'hFFFE, 1'b0));
        vecs.push_back(mk(16'hFF9C, 16'd0,   16'hFFFF, 16'hFF9C, 1'b1));
`else
        vecs.push_back(mk(16'hFFFF, 16'd1,   16'hFFFF, 16'd0,    1'b0));
        vecs.push_back(mk(16'h8000, 16'hFFFF,16'd0,    16'h8000, 1'b0));
        vecs.push_back(mk(16'hFFFF, 16'hFFFF,16'd1,    16'd0,    1'b0));
        vecs.push_back(mk(16'hFFFE, 16'd0,   16'hFFFF, 16'hFFFE, 1'b1));
`endif

        // Reset state
        rst_n = 1'b0;
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_q",    32'(bus.quotient), 32'd0);
        check("rst_r",    32'(bus.remainder), 32'd0);
        check("rst_dbz",  32'(bus.div_by_zero), 32'd0);
        rst_n = 1'b1;

        // Table, back to back: each start lands in the IDLE cycle right after DONE.
        for (int i = 0; i < vecs.size(); i++) run_div($sformatf("vec%0d", i), vecs[i]);

        // Results hold while idle.
        repeat (5) @(negedge clk);
        v = vecs[vecs.size()-1];
        check("hold_q",   32'(bus.quotient), 32'(v.q));
        check("hold_dbz", 32'(bus.div_by_zero), 32'(v.dbz));

        // Zero divisor then a normal division clears the flag.
        run_div("dbz_1234", mk(16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1));
        run_div("after_dbz", mk(16'd9, 16'd3, 16'd3, 16'd0, 1'b0));

        // A start during ITER is ignored: single done with 50/5's result.
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 16'd50; bus.divisor = 16'd5;
        e.q = 16'd10; e.r = 16'd0; e.dbz = 1'b0; e.lat = W + 2;
        sb.push_back(e);
        dc = done_cnt;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.dividend = 16'd9; bus.divisor = 16'd3;
        check("iter_q_held", 32'(bus.quotient), 32'd3);
        @(negedge clk);
        bus.start = 1'b0;
        begin : ign_wait
            int k;
            bit seen;
            k = 4; seen = 0;
            for (int i = 0; i < 64 && !seen; i++) begin
                @(negedge clk);
                k++;
                if (bus.done) seen = 1;
            end
            e = sb.pop_front();
            if (!seen) begin
                n_tests++; n_fail++;
                $display("[TB] FAIL ign_timeout: got no done, expected one after %0d", e.lat);
            end else begin
                check("ign_lat", 32'(k), 32'(e.lat));
                check("ign_q",   32'(bus.quotient), 32'(e.q));
                check("ign_r",   32'(bus.remainder), 32'(e.r));
            end
        end
        repeat (W + 5) @(negedge clk);
        check("ign_one_done", 32'(done_cnt - dc), 32'd1);

        // Reset mid-division: outputs clear at once, no done, next start is fresh.
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 16'h1234; bus.divisor = 16'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        dc = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_q",    32'(bus.quotient), 32'd0);
        check("mid_rst_r",    32'(bus.remainder), 32'd0);
        check("mid_rst_dbz",  32'(bus.div_by_zero), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 4) @(negedge clk);
        check("mid_rst_no_done", 32'(done_cnt - dc), 32'd0);
`ifdef DIVIDER_ITER_SIGNED_EN
        run_div("post_rst", mk(16'hFFFF, 16'd2, 16'd0, 16'hFFFF, 1'b0));
`else
        run_div("post_rst", mk(16'hFFFF, 16'd2, 16'h7FFF, 16'd1, 1'b0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/divider_iter.md
DIVIDER_ITER -- requirements
Module: divider_iter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand, quotient and remainder width in bits; the legal range is 4..32.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port start, input, 1 bit: request to begin a division; sampled only in IDLE.
REQ-005 Port dividend, input, WIDTH bits: numerator, sampled at the edge that accepts start.
REQ-006 Port divisor, input, WIDTH bits: denominator, sampled at the edge that accepts start.
REQ-007 Port busy, output, 1 bit: high in every state except IDLE.
REQ-008 Port done, output, 1 bit: one-cycle pulse that marks a valid result.
REQ-009 Port quotient, output, WIDTH bits: registered result.
REQ-010 Port remainder, output, WIDTH bits: registered result.
REQ-011 Port div_by_zero, output, 1 bit: registered flag, valid from the done pulse onward.

Function
REQ-012 The FSM SHALL have states IDLE, ITER, FIX and DONE; the reset state is IDLE.
REQ-013 In IDLE, start=1 at edge E0 SHALL capture the operand magnitudes and load the iteration counter with WIDTH.
- Divisor nonzero: next state is ITER.
- Divisor zero: next state is DONE.
REQ-014 ITER SHALL perform one restoring shift/subtract step per clock, decrement the counter each step, and go to FIX after exactly WIDTH steps (edges E1..E_WIDTH).
REQ-015 FIX SHALL apply sign correction, load quotient, remainder and div_by_zero (edge E_WIDTH+1), and go to DONE.
REQ-016 done SHALL be high only during DONE, which lasts exactly one cycle; the next state is IDLE.
- Nonzero divisor: done is high in the cycle after edge E_WIDTH+1, giving a latency of WIDTH+1 edges.
REQ-017 A divide by zero SHALL produce quotient all-ones, remainder equal to dividend, div_by_zero=1, and done in the cycle after E0.
REQ-018 div_by_zero SHALL clear when the next division's result is loaded.
REQ-019 start SHALL be ignored in ITER, FIX and DONE; no operand is captured and no result is disturbed.
REQ-020 quotient, remainder and div_by_zero SHALL hold their last values until the next result is loaded.
REQ-021 The internal partial-remainder register SHALL be WIDTH+1 bits so the trial subtraction never loses its borrow.
REQ-022 Back-to-back operation: start high in the cycle after DONE SHALL be accepted, giving one division per WIDTH+3 cycles.

Reset
REQ-023 rst_n=0 SHALL immediately force the following, regardless of clk:
- state IDLE, counter 0;
- busy=0, done=0;
- quotient=0, remainder=0, div_by_zero=0.
REQ-024 Reset asserted mid-operation SHALL abandon the division with no done pulse.
- The first start accepted after rst_n deasserts begins a fresh division.

Configuration
REQ-025 Macro DIVIDER_ITER_SIGNED_EN defined: operands and results are two's complement.
- Division operates on magnitudes.
- Quotient is negated when the operand signs differ; the quotient truncates toward zero.
- Remainder takes the sign of the dividend.
- -2^(WIDTH-1) / -1 gives quotient -2^(WIDTH-1) (wrap) and remainder 0.
REQ-026 Macro DIVIDER_ITER_SIGNED_EN undefined: operands are unsigned, FIX performs no negation, and FIX still costs its one cycle so latency is identical in both builds.

Structure
REQ-027 Package divider_pkg SHALL hold:
- the state enum typedef;
- localparams for the minimum and maximum WIDTH.
REQ-028 Sub-module divider_step SHALL be a purely combinational single restoring step.
- Inputs: partial remainder, next dividend bit, divisor.
- Outputs: new partial remainder and quotient bit.
- divider_iter SHALL instantiate it exactly once.

Verification (WIDTH=16)
REQ-029 Unsigned-or-signed build, 100/7: done 17 edges after start; quotient=14, remainder=2, div_by_zero=0.
REQ-030 Signed build:
- -100/7: quotient=0xFFF2, remainder=0xFFFE.
- 0x8000/0xFFFF: quotient=0x8000, remainder=0.
REQ-031 1234/0: done one cycle after start; quotient=0xFFFF, remainder=1234, div_by_zero=1.
- A following 9/3 gives quotient=3 and clears div_by_zero.
REQ-032 Start 50/5, pulse start again with 9/3 during ITER: exactly one done, with quotient=10, remainder=0.
REQ-033 rst_n low at cycle 8 of a division:
- all outputs 0 immediately;
- no done pulse;
- a subsequent 0xFFFF/2 in the unsigned build gives quotient=0x7FFF, remainder=1.
